// File: rtl/mesa_ro_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mesa_ro_arb
//  Purpose  : Packet-level round-robin arbiter for the shared MesaBus Ro byte
//             path. One source owns the path from first byte through done;
//             its stream is registered onto ro_byte_en/ro_byte_d/ro_done.
//  Options  : MESA_RO_ARB_WDOG_EN - build the idle watchdog that forces a
//             release after WDOG_CYCLES silent cycles in GRANT.
//  Revision : 1.0  initial release
// ============================================================================
module mesa_ro_arb #(
   parameter int NUM_REQ     = 3,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                  clk_lb,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_rq,
   output logic [NUM_REQ-1:0]    req_gnt,
   input  logic [NUM_REQ-1:0]    req_byte_en,
   input  logic [8*NUM_REQ-1:0]  req_byte_d,
   input  logic [NUM_REQ-1:0]    req_done,
   output logic [NUM_REQ-1:0]    req_busy,
   output logic                  ro_byte_en,
   output logic [7:0]            ro_byte_d,
   output logic                  ro_done,
   input  logic                  ro_busy,
   output logic                  err_drop,
   output logic                  err_wdog
);

   localparam int c_RR_W = $clog2(NUM_REQ);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_GRANT = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  w_gnt_nxt;
   logic [c_RR_W-1:0]   r_rr;
   logic [c_RR_W-1:0]   w_rr_nxt;
   logic [c_RR_W-1:0]   w_win;
   logic                w_any_rq;
   logic                w_g_en;
   logic [7:0]          w_g_d;
   logic                w_g_done;
   logic                w_drop;
   logic                w_wdog_fire;
   logic                r_ro_en;
   logic [7:0]          r_ro_d;
   logic                r_ro_done;
   logic                r_err_drop;
   logic                w_ro_en_nxt;
   logic [7:0]          w_ro_d_nxt;
   logic                w_ro_done_nxt;

   // Round-robin search: first requester at or above the pointer, with wrap.
   always_comb begin
      w_win    = '0;
      w_any_rq = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_any_rq && req_rq[(int'(r_rr) + i) % NUM_REQ]) begin
            w_any_rq = 1'b1;
            w_win    = c_RR_W'((int'(r_rr) + i) % NUM_REQ);
         end
      end
   end

   // Mux the currently granted source's stream (grant is one-hot or zero).
   always_comb begin
      w_g_en   = 1'b0;
      w_g_d    = 8'h00;
      w_g_done = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gnt[i]) begin
            w_g_en   = w_g_en   | req_byte_en[i];
            w_g_d    = w_g_d    | req_byte_d[8*i +: 8];
            w_g_done = w_g_done | req_done[i];
         end
      end
   end

   // Any strobe or done from a source that does not own the path is discarded.
   assign w_drop = |((req_byte_en | req_done) & ~r_gnt);

`ifdef MESA_RO_ARB_WDOG_EN
   localparam int c_WC_W = $clog2(WDOG_CYCLES + 1);

   logic [c_WC_W-1:0] r_wcnt;
   logic              r_err_wdog;

   // A done on the expiry cycle is an ordinary release, not a watchdog event.
   assign w_wdog_fire = (r_state == c_GRANT) && !w_g_en && !w_g_done &&
                        (r_wcnt == c_WC_W'(WDOG_CYCLES - 1));

   // Silence counter: held at zero outside GRANT, cleared by every granted byte.
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         r_wcnt     <= '0;
         r_err_wdog <= 1'b0;
      end else begin
         if ((r_state != c_GRANT) || w_g_en) begin
            r_wcnt <= '0;
         end else begin
            r_wcnt <= r_wcnt + c_WC_W'(1);
         end
         if (w_wdog_fire) begin
            r_err_wdog <= 1'b1;
         end
      end
   end

   assign err_wdog = r_err_wdog;
`else
   assign w_wdog_fire = 1'b0;

   // Without the watchdog the grant is held indefinitely and the flag never sets.
   if (WDOG_CYCLES > 0) begin : g_wdog_off
      assign err_wdog = 1'b0;
   end else begin : g_wdog_off_zero
      assign err_wdog = 1'b0;
   end
`endif

   // Next-state: arbitrate only from IDLE, release on done, drain until phy idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_any_rq)                  w_state_nxt = c_GRANT;
         c_GRANT: if (w_g_done || w_wdog_fire)   w_state_nxt = c_DRAIN;
         c_DRAIN: if (!ro_busy)                  w_state_nxt = c_IDLE;
         default:                                w_state_nxt = c_IDLE;
      endcase
   end

   // Next values of the registered outputs, grant and round-robin pointer.
   always_comb begin
      w_gnt_nxt     = r_gnt;
      w_rr_nxt      = r_rr;
      w_ro_en_nxt   = 1'b0;
      w_ro_d_nxt    = r_ro_d;
      w_ro_done_nxt = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_any_rq) begin
               w_gnt_nxt        = '0;
               w_gnt_nxt[w_win] = 1'b1;
               w_rr_nxt         = c_RR_W'((int'(w_win) + 1) % NUM_REQ);
            end
         end
         c_GRANT: begin
            w_ro_en_nxt   = w_g_en;
            w_ro_done_nxt = w_g_done | w_wdog_fire;
            if (w_g_en) begin
               w_ro_d_nxt = w_g_d;
            end
            if (w_g_done || w_wdog_fire) begin
               w_gnt_nxt = '0;
            end
         end
         default: begin
            w_gnt_nxt = '0;
         end
      endcase
   end

   // State, grant, pointer and output registers; reset aborts any packet.
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_gnt      <= '0;
         r_rr       <= '0;
         r_ro_en    <= 1'b0;
         r_ro_d     <= 8'h00;
         r_ro_done  <= 1'b0;
         r_err_drop <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_rr       <= w_rr_nxt;
         r_ro_en    <= w_ro_en_nxt;
         r_ro_d     <= w_ro_d_nxt;
         r_ro_done  <= w_ro_done_nxt;
         r_err_drop <= r_err_drop | w_drop;
      end
   end

   assign req_gnt    = r_gnt;
   assign req_busy   = {NUM_REQ{ro_busy}} | ~r_gnt;
   assign ro_byte_en = r_ro_en;
   assign ro_byte_d  = r_ro_d;
   assign ro_done    = r_ro_done;
   assign err_drop   = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_mesa_ro_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mesa_ro_arb
//  Purpose  : Directed self-checking bench for mesa_ro_arb (NUM_REQ=3,
//             WDOG_CYCLES=16). The watchdog scenario follows
//             MESA_RO_ARB_WDOG_EN when it is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mesa_ro_arb;

   logic        clk_lb;
   logic        reset;
   logic [2:0]  req_rq;
   logic [2:0]  req_gnt;
   logic [2:0]  req_byte_en;
   logic [23:0] req_byte_d;
   logic [2:0]  req_done;
   logic [2:0]  req_busy;
   logic        ro_byte_en;
   logic [7:0]  ro_byte_d;
   logic        ro_done;
   logic        ro_busy;
   logic        err_drop;
   logic        err_wdog;

   int n_checks = 0;
   int n_errors = 0;

   mesa_ro_arb #(
      .NUM_REQ     (3),
      .WDOG_CYCLES (16)
   ) u_dut (
      .clk_lb      (clk_lb),
      .reset       (reset),
      .req_rq      (req_rq),
      .req_gnt     (req_gnt),
      .req_byte_en (req_byte_en),
      .req_byte_d  (req_byte_d),
      .req_done    (req_done),
      .req_busy    (req_busy),
      .ro_byte_en  (ro_byte_en),
      .ro_byte_d   (ro_byte_d),
      .ro_done     (ro_done),
      .ro_busy     (ro_busy),
      .err_drop    (err_drop),
      .err_wdog    (err_wdog)
   );

   // Free-running clock
   initial clk_lb = 1'b0;
   always #5 clk_lb = ~clk_lb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs take effect at posedge, outputs sampled at the negedge.
   task automatic tick();
      @(posedge clk_lb);
      @(negedge clk_lb);
   endtask

   task automatic idle_in();
      req_byte_en = '0;
      req_done    = '0;
   endtask

   task automatic drive(input int src, input logic en, input logic [7:0] d, input logic dn);
      idle_in();
      req_byte_en[src]       = en;
      req_byte_d[8*src +: 8] = d;
      req_done[src]          = dn;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      req_rq  = '0;
      ro_busy = 1'b0;
      idle_in();
      tick();
      reset   = 1'b0;
   endtask

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "time limit");
   end

   logic [2:0] exp_gnt [4];
   int         exp_src [4];

   initial begin
      exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_src = '{0, 1, 2, 0};
      reset = 1'b1; req_rq = '0; req_byte_en = '0; req_byte_d = '0;
      req_done = '0; ro_busy = 1'b0;
      @(negedge clk_lb);
      tick();
      check("rst_gnt",  req_gnt, 3'b000);
      check("rst_en",   ro_byte_en, 1'b0);
      check("rst_d",    ro_byte_d, 8'h00);
      check("rst_done", ro_done, 1'b0);
      check("rst_drop", err_drop, 1'b0);
      check("rst_wdog", err_wdog, 1'b0);
      reset = 1'b0;

      // 1: single packet from source 1
      req_rq = 3'b010;
      tick();
      check("t1_gnt",  req_gnt, 3'b010);
      check("t1_busy", req_busy, 3'b101);
      req_rq = '0;
      drive(1, 1'b1, 8'hA5, 1'b0);
      tick();
      check("t1_en0", ro_byte_en, 1'b1);
      check("t1_d0",  ro_byte_d, 8'hA5);
      drive(1, 1'b1, 8'h3C, 1'b0);
      tick();
      check("t1_d1", ro_byte_d, 8'h3C);
      idle_in();
      tick();
      check("t1_en_off", ro_byte_en, 1'b0);
      check("t1_d_hold", ro_byte_d, 8'h3C);
      drive(1, 1'b0, 8'h00, 1'b1);
      tick();
      check("t1_done",    ro_done, 1'b1);
      check("t1_gnt_off", req_gnt, 3'b000);
      check("t1_d_hold2", ro_byte_d, 8'h3C);
      idle_in();
      tick();
      check("t1_done_off", ro_done, 1'b0);
      check("t1_drop",     err_drop, 1'b0);

      // 2: all three requesting, round-robin from 0
      do_reset();
      req_rq = 3'b111;
      tick();
      for (int p = 0; p < 4; p++) begin
         check("t2_gnt", req_gnt, exp_gnt[p]);
         drive(exp_src[p], 1'b1, 8'(8'h50 + p), 1'b1);
         if (p == 3) req_rq = '0;
         tick();
         check("t2_en",   ro_byte_en, 1'b1);
         check("t2_d",    ro_byte_d, 8'h50 + p);
         check("t2_done", ro_done, 1'b1);
         check("t2_gap1", req_gnt, 3'b000);
         idle_in();
         tick();
         check("t2_gap2", req_gnt, 3'b000);
         check("t2_quiet", ro_byte_en, 1'b0);
         if (p < 3) tick();
      end

      // 3: stray strobe from a non-granted source
      do_reset();
      req_rq = 3'b001;
      tick();
      check("t3_gnt", req_gnt, 3'b001);
      req_rq = '0;
      drive(0, 1'b1, 8'h11, 1'b0);
      req_byte_en[2]       = 1'b1;
      req_byte_d[23:16]    = 8'hFF;
      tick();
      check("t3_d0",   ro_byte_d, 8'h11);
      check("t3_drop", err_drop, 1'b1);
      drive(0, 1'b1, 8'h22, 1'b0);
      tick();
      check("t3_d1",    ro_byte_d, 8'h22);
      check("t3_drop1", err_drop, 1'b1);
      drive(0, 1'b0, 8'h00, 1'b1);
      tick();
      check("t3_done", ro_done, 1'b1);
      idle_in();
      tick();
      tick();
      check("t3_sticky", err_drop, 1'b1);

      // 4: phy busy stretches DRAIN
      do_reset();
      check("t4_drop_clr", err_drop, 1'b0);
      req_rq = 3'b001;
      tick();
      check("t4_gnt0", req_gnt, 3'b001);
      req_rq  = 3'b010;
      ro_busy = 1'b1;
      drive(0, 1'b0, 8'h00, 1'b1);
      tick();
      check("t4_done", ro_done, 1'b1);
      idle_in();
      for (int k = 0; k < 9; k++) begin
         tick();
         check("t4_hold", req_gnt, 3'b000);
         check("t4_busy", req_busy, 3'b111);
      end
      ro_busy = 1'b0;
      tick();
      check("t4_idle", req_gnt, 3'b000);
      tick();
      check("t4_gnt1", req_gnt, 3'b010);
      req_rq = '0;
      drive(1, 1'b0, 8'h00, 1'b1);
      tick();
      idle_in();
      tick();
      tick();

      // 5: reset in mid-packet
      do_reset();
      req_rq = 3'b010;
      tick();
      check("t5_gnt", req_gnt, 3'b010);
      req_rq = '0;
      drive(1, 1'b1, 8'h77, 1'b0);
      tick();
      drive(1, 1'b1, 8'h88, 1'b0);
      tick();
      check("t5_d1", ro_byte_d, 8'h88);
      drive(1, 1'b0, 8'h00, 1'b1);
      reset = 1'b1;
      tick();
      check("t5_gnt_rst",  req_gnt, 3'b000);
      check("t5_en_rst",   ro_byte_en, 1'b0);
      check("t5_d_rst",    ro_byte_d, 8'h00);
      check("t5_done_rst", ro_done, 1'b0);
      reset = 1'b0;
      idle_in();
      req_rq = 3'b110;
      tick();
      check("t5_rr0", req_gnt, 3'b010);
      req_rq = '0;
      drive(1, 1'b0, 8'h00, 1'b1);
      tick();
      idle_in();
      tick();
      tick();

      // 6: long silence in GRANT
      do_reset();
      req_rq = 3'b001;
      tick();
      check("t6_gnt", req_gnt, 3'b001);
      req_rq = '0;
      drive(0, 1'b1, 8'h5A, 1'b0);
      tick();
      idle_in();
      check("t6_byte", ro_byte_en, 1'b1);
`ifdef MESA_RO_ARB_WDOG_EN
      for (int k = 0; k < 15; k++) begin
         tick();
         check("t6_quiet", ro_done, 1'b0);
      end
      tick();
      check("t6_wdog_done", ro_done, 1'b1);
      check("t6_wdog_flag", err_wdog, 1'b1);
      check("t6_wdog_gnt",  req_gnt, 3'b000);
      drive(0, 1'b0, 8'h00, 1'b1);
      tick();
      idle_in();
      check("t6_late_drop", err_drop, 1'b1);
      tick();
      tick();
`else
      for (int k = 0; k < 110; k++) begin
         tick();
         check("t6_held", req_gnt, 3'b001);
      end
      check("t6_no_done", ro_done, 1'b0);
      check("t6_no_wdog", err_wdog, 1'b0);
      drive(0, 1'b0, 8'h00, 1'b1);
      tick();
      check("t6_done", ro_done, 1'b1);
      idle_in();
      tick();
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
